// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// emit one-cycle enable pulses at f_ref*inc/2^ACC_W, with a PLL-style settle flag.
module frac_clken_gen #(
   parameter int NUM_CH      = 2,
   parameter int ACC_W       = 16,
   parameter int DEF_INC     = 52429,
   parameter int LOCK_CYCLES = 256
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   output logic [NUM_CH-1:0] outen,
   output logic [NUM_CH-1:0] outtgl,
   output logic              locked
);

   localparam int LCW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

   logic [ACC_W-1:0]  r_acc [NUM_CH];
   logic [ACC_W-1:0]  r_inc [NUM_CH];
   logic [NUM_CH-1:0] r_outen;
   logic [NUM_CH-1:0] r_outtgl;
   logic              r_pending;
   logic [2:0]        r_cap_ch;
   logic [ACC_W-1:0]  r_cap_inc;
   logic [ACC_W-1:0]  r_cap_phase;
   logic [LCW-1:0]    r_lock_cnt;
   logic              r_locked;

   logic [ACC_W:0]    w_sum [NUM_CH];
   logic [NUM_CH-1:0] w_carry;
   logic [NUM_CH-1:0] w_apply;
   logic              w_any_apply;
   logic              w_accept;
   logic              w_ch_ok;
   logic [LCW-1:0]    w_cnt_next;

   // Config port: a request transfers on any edge where cfg_valid && cfg_ready.
   // cfg_ready stays low from acceptance until the captured config is applied, so
   // the captured fields can never be overwritten while waiting for a boundary.
   assign cfg_ready = !r_pending;
   assign w_accept  = cfg_valid && !r_pending;
   assign w_ch_ok   = (32'(cfg_ch) < NUM_CH);

   // Apply only at a period boundary (carry) or on an idle channel, so a running
   // period is never cut short or stretched by reprogramming.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
         w_carry[i] = w_sum[i][ACC_W];
         w_apply[i] = r_pending && (r_cap_ch == 3'(i)) &&
                      ((r_inc[i] == '0) || w_sum[i][ACC_W]);
      end
   end

   assign w_any_apply = |w_apply;

   always_comb begin
      if (w_any_apply)
         w_cnt_next = '0;
      else if (r_lock_cnt == LOCK_MAX)
         w_cnt_next = r_lock_cnt;
      else
         w_cnt_next = r_lock_cnt + LCW'(1);
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_acc[i] <= '0;
            r_inc[i] <= ACC_W'(DEF_INC);
         end
         r_outen     <= '0;
         r_outtgl    <= '0;
         r_pending   <= 1'b0;
         r_cap_ch    <= '0;
         r_cap_inc   <= '0;
         r_cap_phase <= '0;
         r_lock_cnt  <= '0;
         r_locked    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_apply[i]) begin
               r_inc[i] <= r_cap_inc;
               r_acc[i] <= r_cap_phase;
            end else begin
               r_acc[i] <= w_sum[i][ACC_W-1:0];
            end
         end
         // The carry pulse of the apply edge is still issued.
         r_outen  <= w_carry;
         r_outtgl <= r_outtgl ^ w_carry;

         if (w_any_apply) begin
            r_pending <= 1'b0;
         end else if (w_accept && w_ch_ok) begin
            r_pending   <= 1'b1;
            r_cap_ch    <= cfg_ch;
            r_cap_inc   <= cfg_inc;
            r_cap_phase <= cfg_phase;
         end

         r_lock_cnt <= w_cnt_next;
         r_locked   <= (w_cnt_next == LOCK_MAX);
      end
   end

   assign outen  = r_outen;
   assign outtgl = r_outtgl;
   assign locked = r_locked;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen: reset defaults, lock timing, aligned and
// disabled-channel reprogramming, invalid channel, and reset while pending.
module tb_frac_clken_gen;

   logic        refclk    = 1'b0;
   logic        rst       = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [2:0]  cfg_ch    = '0;
   logic [15:0] cfg_inc   = '0;
   logic [15:0] cfg_phase = '0;
   logic [1:0]  outen;
   logic [1:0]  outtgl;
   logic        locked;

   int n_checks = 0;
   int n_errors = 0;
   int k        = 0;

   frac_clken_gen #(
      .NUM_CH(2), .ACC_W(16), .DEF_INC(16384), .LOCK_CYCLES(256)
   ) dut (
      .refclk(refclk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
      .outen(outen), .outtgl(outtgl), .locked(locked)
   );

   always #5 refclk = ~refclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      k++;
      #1;
   endtask

   task automatic send_cfg(input logic [2:0] ch, input logic [15:0] inc, input logic [15:0] phase);
      cfg_ch    = ch;
      cfg_inc   = inc;
      cfg_phase = phase;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      // Reset defaults
      rst = 1'b0;
      for (int e = 0; e < 3; e++) begin
         tick();
         check_eq("rst_outen", outen, 0);
         check_eq("rst_outtgl", outtgl, 0);
         check_eq("rst_ready", cfg_ready, 1);
         check_eq("rst_locked", locked, 0);
      end
      rst = 1'b1;
      k   = 0;

      // Default pulse train and lock timing
      for (int e = 1; e <= 260; e++) begin
         tick();
         check_eq("def_outen", outen, (k % 4 == 0) ? 32'd3 : 32'd0);
         check_eq("def_outtgl", outtgl, ((k / 4) % 2 == 1) ? 32'd3 : 32'd0);
         if (k >= 254) check_eq("lock_time", locked, (k >= 256) ? 32'd1 : 32'd0);
      end

      // Aligned reprogram of ch0 to inc=32768, accepted one cycle after a pulse
      send_cfg(3'd0, 16'd32768, 16'd0);
      check_eq("al_ready_acc", cfg_ready, 0);
      while (k < 520) begin
         tick();
         check_eq("al_ready", cfg_ready, (k >= 264) ? 32'd1 : 32'd0);
         check_eq("al_outen0", outen[0], (k >= 264) ? ((k % 2 == 0) ? 32'd1 : 32'd0)
                                                     : ((k % 4 == 0) ? 32'd1 : 32'd0));
         check_eq("al_outen1", outen[1], (k % 4 == 0) ? 32'd1 : 32'd0);
         check_eq("al_locked", locked, ((k < 264) || (k >= 520)) ? 32'd1 : 32'd0);
      end

      // Disable ch1
      send_cfg(3'd1, 16'd0, 16'd0);
      check_eq("dis_ready_acc", cfg_ready, 0);
      while (k < 540) begin
         tick();
         check_eq("dis_ready", cfg_ready, (k >= 524) ? 32'd1 : 32'd0);
         check_eq("dis_outen1", outen[1], ((k % 4 == 0) && (k <= 524)) ? 32'd1 : 32'd0);
         check_eq("dis_outtgl1", outtgl[1], (k >= 524) ? 32'd1 : 32'(((k / 4) % 2)));
         check_eq("dis_outen0", outen[0], (k % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("dis_locked", locked, (k < 524) ? 32'd1 : 32'd0);
      end

      // Re-enable ch1 at max increment: applies on the edge after acceptance
      send_cfg(3'd1, 16'hFFFF, 16'hFFFF);
      check_eq("max_ready_acc", cfg_ready, 0);
      check_eq("max_outen1_acc", outen[1], 0);
      tick();
      check_eq("max_ready_app", cfg_ready, 1);
      check_eq("max_outen1_app", outen[1], 0);
      check_eq("max_outtgl1_app", outtgl[1], 1);
      check_eq("max_locked_app", locked, 0);
      while (k < 800) begin
         tick();
         check_eq("max_outen1", outen[1], 1);
         check_eq("max_outtgl1", outtgl[1], ((k - 543) % 2 == 0) ? 32'd0 : 32'd1);
         check_eq("max_outen0", outen[0], (k % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("max_locked", locked, (k >= 798) ? 32'd1 : 32'd0);
      end

      // Invalid channel: accepted and dropped
      send_cfg(3'd5, 16'd1, 16'd0);
      check_eq("inv_ready_acc", cfg_ready, 1);
      check_eq("inv_locked_acc", locked, 1);
      while (k < 810) begin
         tick();
         check_eq("inv_ready", cfg_ready, 1);
         check_eq("inv_locked", locked, 1);
         check_eq("inv_outen", outen, (k % 2 == 0) ? 32'd3 : 32'd2);
      end

      // Reset while a config is pending on ch0
      send_cfg(3'd0, 16'd1, 16'd0);
      check_eq("rp_ready_acc", cfg_ready, 0);
      rst = 1'b0;
      #1;
      check_eq("rp_ready_rst", cfg_ready, 1);
      check_eq("rp_locked_rst", locked, 0);
      check_eq("rp_outen_rst", outen, 0);
      check_eq("rp_outtgl_rst", outtgl, 0);
      tick();
      tick();
      rst = 1'b1;
      k   = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         check_eq("rp_outen", outen, (k % 4 == 0) ? 32'd3 : 32'd0);
         check_eq("rp_ready", cfg_ready, 1);
         check_eq("rp_locked", locked, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/frac_clken_gen.md
Name: frac_clken_gen

Overview:
- Parametrised multi-channel clock-enable generator. Runs entirely in the refclk domain and does not instantiate a PLL.
- Each channel has a phase accumulator that produces single-cycle enable pulses at f_ref*INC/2^ACC_W. A toggle output derived from the pulses gives a square wave at half that rate.
- Channels can be reprogrammed at runtime through a valid/ready config port.
- A settle-count `locked` flag mimics PLL lock semantics, so VGA/pixel logic can gate on it exactly as it would on a PLL.

Parameters:
- NUM_CH, 2, number of independent enable channels (1..8)
- ACC_W, 16, accumulator width in bits
- DEF_INC, 52429, reset increment for every channel (about 40 MHz equivalent from a 50 MHz refclk)
- LOCK_CYCLES, 256, refclk cycles after reset or reconfig before `locked` asserts (>=1)

Ports:
- refclk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config port can accept a request
- cfg_ch  in  3  target channel index
- cfg_inc  in  ACC_W  new increment; 0 disables the channel
- cfg_phase  in  ACC_W  accumulator value loaded when the config is applied
- outen  out  NUM_CH  per-channel one-cycle enable pulse
- outtgl  out  NUM_CH  per-channel toggle, inverts on each outen pulse
- locked  out  1  all channels stable for LOCK_CYCLES cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - acc=0 and inc=DEF_INC on all channels.
  - outen=0, outtgl=0, locked=0, lock counter=0.
  - pending=0, so cfg_ready=1.
- Accumulator, each rising edge, per channel i:
  - {carry, sum} = acc + inc, computed at ACC_W+1 bits; sum wraps modulo 2^ACC_W.
  - acc <= sum.
  - outen[i] <= carry (registered, high for exactly one cycle per carry).
  - outtgl[i] <= outtgl[i] ^ carry.
- Disabled channel (inc=0): acc holds, outen stays 0, outtgl holds.
- Config handshake:
  - cfg_ready = !pending.
  - Accept condition: cfg_valid && cfg_ready. On accept, cfg_ch, cfg_inc and cfg_phase are captured and pending is set.
  - cfg_ch >= NUM_CH: the request is accepted and discarded. pending is not set and the lock counter is not affected.
- Apply:
  - Earliest apply is the cycle after acceptance.
  - Apply occurs on the first edge at which the target channel's inc==0 or its carry=1. Reprogramming therefore never shortens or stretches a running period.
  - On apply: inc <= captured inc, acc <= captured phase (instead of sum), pending <= 0, lock counter <= 0.
  - The outen pulse from that edge's carry is still issued.
- Boundaries:
  - A new request cannot be accepted in the apply cycle, because cfg_ready is low while pending.
  - If the old inc is nonzero but tiny, apply waits up to 2^ACC_W/inc cycles. No timeout exists.
  - inc = 2^ACC_W-1 yields outen high on all cycles except one per 2^ACC_W.
- Lock:
  - The counter increments each cycle and saturates at LOCK_CYCLES.
  - locked = (counter == LOCK_CYCLES), registered. It asserts on the LOCK_CYCLES-th edge after rst release or after an apply.
  - locked drops to 0 on the edge of an apply. An accept alone does not drop it.
- Reset mid-pending: pending and captured values are lost, and all channels return to DEF_INC.

Test Plan:
- Reset defaults:
  - Stimulus: hold rst=0 for 3 cycles, then release; NUM_CH=2, DEF_INC=16384.
  - Required: outen=0 and cfg_ready=1 during reset. outen[0] and outen[1] first go high after the 4th edge, then every 4 cycles. outtgl has period 8.
- Lock timing:
  - Stimulus: LOCK_CYCLES=256, release reset.
  - Required: locked=0 through edge 255 and 1 from edge 256 onward.
- Aligned reprogram:
  - Stimulus: ch0 inc=16384; send cfg ch0, inc=32768, phase=0, accepted 1 cycle after an outen pulse.
  - Required: cfg_ready=0 until the next carry 3 cycles later. Pulse spacing is 4 cycles up to and including the apply, then 2. locked=0 from the apply edge, 1 again 256 edges later.
- Disabled channel:
  - Stimulus: cfg ch1, inc=0; then cfg ch1, inc=65535, phase=65535.
  - Required: after the first apply, outen[1] stays 0 and outtgl[1] is frozen. The second config applies on the edge after acceptance, and outen[1] pulses on the next edge.
- Invalid channel:
  - Stimulus: cfg_ch=5 with NUM_CH=2, while locked=1.
  - Required: cfg_ready stays 1, locked stays 1, pulse pattern on both channels unchanged.
- Reset during pending:
  - Stimulus: accept cfg ch0 inc=1, then assert rst before the carry.
  - Required: pending clears, ch0 runs DEF_INC after release, locked restarts at 0.
